// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C EEPROM responder.
package i2c_pkg;

  localparam int   I2C_ADDR_W = 7;
  localparam int   I2C_DATA_W = 8;
  localparam logic RW_WRITE   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser for one bus line, with registered single-cycle rise/fall events.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q, rise_q, fall_q;

  // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  // prev_q changes on the same clk the event register fires.
  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_eeprom_responder.sv
// I2C-style EEPROM responder: one addressed byte read or written per transfer, LSB first.
// Optional write-protect input enabled by defining EEPROM_WP_EN.
//
// state     | meaning
// IDLE      | bus free, sda released
// ADDR      | shifting in {addr, rw}
// ADDR_ACK  | driving ACK for the address byte
// WDATA     | shifting in the write byte
// WDATA_ACK | driving ACK (or NACK when protected) for the write byte
// RDATA     | driving the stored byte onto sda
// WAIT_STOP | transfer complete, waiting for STOP or START
module i2c_eeprom_responder
  import i2c_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = I2C_ADDR_W,
  parameter int DATA_W = I2C_DATA_W
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  inout  wire  sda,
  output logic ack,
  output logic done,
  output logic busy
`ifdef EEPROM_WP_EN
  ,
  input  logic wp
`endif
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_ev, stop_ev;

  i2c_line_sync u_scl_sync (
    .clk     (clk),
    .rst     (rst),
    .din_i   (scl),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk     (clk),
    .rst     (rst),
    .din_i   (sda),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  assign start_ev = sda_fall & scl_lvl;
  assign stop_ev  = sda_rise & scl_lvl;

  i2c_state_e          state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   sh_q, sh_d, sh_in;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic                oe_q, oe_d;
  logic                ack_q, ack_d;
  logic                done_q, done_d;
  logic                blk_q, blk_d;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  assign sh_in = {sda_lvl, sh_q[DATA_W-1:1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      blk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      blk_q   <= blk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    oe_d      = oe_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    blk_d     = blk_q;
    mem_we    = 1'b0;
    mem_wdata = sh_in;

    if ((state_q != IDLE) && stop_ev) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      ack_d   = 1'b0;
      done_d  = (state_q == WAIT_STOP);
    end else if (start_ev) begin
      // Also covers repeated START: any partial byte is simply dropped.
      state_d = ADDR;
      cnt_d   = '0;
      sh_d    = '0;
      oe_d    = 1'b0;
      ack_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            sh_d  = sh_in;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              addr_d  = sh_in[ADDR_W:1];
              rw_d    = sh_in[0];
              rd_d    = mem_q[sh_in[ADDR_W:1]];
              cnt_d   = '0;
              state_d = ADDR_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              cnt_d = 3'd1;
              oe_d  = 1'b1;
              ack_d = 1'b1;
            end else begin
              cnt_d = '0;
              ack_d = 1'b0;
              if (rw_q == RW_WRITE) begin
                oe_d    = 1'b0;
                state_d = WDATA;
              end else begin
                oe_d    = ~rd_q[0];
                state_d = RDATA;
              end
            end
          end
        end
        WDATA: begin
          if (scl_rise) begin
            sh_d  = sh_in;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
`ifdef EEPROM_WP_EN
              blk_d = wp;
`else
              blk_d = 1'b0;
`endif
              mem_we  = ~blk_d;
              cnt_d   = '0;
              state_d = WDATA_ACK;
            end
          end
        end
        WDATA_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              cnt_d = 3'd1;
              oe_d  = ~blk_q;
              ack_d = ~blk_q;
            end else begin
              cnt_d   = '0;
              oe_d    = 1'b0;
              ack_d   = 1'b0;
              state_d = WAIT_STOP;
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              cnt_d   = '0;
              oe_d    = 1'b0;
              state_d = WAIT_STOP;
            end else begin
              rd_d  = rd_q >> 1;
              oe_d  = ~rd_q[1];
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        WAIT_STOP: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q] <= mem_wdata;
    end
  end

  assign sda  = oe_q ? 1'b0 : 1'bz;
  assign ack  = ack_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_eeprom_responder.sv
// Directed bench for i2c_eeprom_responder; exercises write protect when EEPROM_WP_EN is defined.
module tb_i2c_eeprom_responder;

  logic clk = 1'b0;
  logic rst;
  logic scl;
  logic sda_drv;
  logic ack, done, busy;
  wire  sda;
`ifdef EEPROM_WP_EN
  logic wp;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  pullup (sda);
  assign sda = sda_drv ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  i2c_eeprom_responder dut (
    .clk  (clk),
    .rst  (rst),
    .scl  (scl),
    .sda  (sda),
    .ack  (ack),
    .done (done),
    .busy (busy)
`ifdef EEPROM_WP_EN
    ,
    .wp   (wp)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Every bus task below ends right at an scl fall (or in idle for do_stop).
  task automatic do_start();
    sda_drv = 1'b0;
    tick(8);
    scl = 1'b1;
    tick(8);
    sda_drv = 1'b1;
    tick(8);
    scl = 1'b0;
  endtask

  task automatic do_stop();
    tick(4);
    sda_drv = 1'b1;
    tick(4);
    scl = 1'b1;
    tick(8);
    sda_drv = 1'b0;
    tick(8);
  endtask

  task automatic bit_write(input logic b);
    tick(4);
    sda_drv = ~b;
    tick(4);
    scl = 1'b1;
    tick(8);
    scl = 1'b0;
  endtask

  task automatic recv_bit(output logic s, output logic a);
    tick(4);
    sda_drv = 1'b0;
    tick(4);
    scl = 1'b1;
    tick(4);
    s = sda;
    a = ack;
    tick(4);
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) bit_write(b[i]);
  endtask

  task automatic recv_byte(output logic [7:0] b);
    logic s, a;
    for (int i = 0; i < 8; i++) begin
      recv_bit(s, a);
      b[i] = s;
    end
  endtask

  task automatic wr_xfer(input string tag, input logic [6:0] a, input logic [7:0] d);
    logic s, k;
    int d0;
    d0 = done_cnt;
    do_start();
    check1({tag, "_busy_start"}, busy, 1'b1);
    send_byte({a, 1'b1});
    recv_bit(s, k);
    check1({tag, "_addr_ack"}, k, 1'b1);
    check1({tag, "_addr_ack_sda"}, s, 1'b0);
    send_byte(d);
    recv_bit(s, k);
    check1({tag, "_data_ack"}, k, 1'b1);
    check1({tag, "_data_ack_sda"}, s, 1'b0);
    do_stop();
    check1({tag, "_busy_end"}, busy, 1'b0);
    check8({tag, "_done_pulses"}, 8'(done_cnt - d0), 8'd1);
  endtask

  task automatic rd_xfer(input string tag, input logic [6:0] a, output logic [7:0] d);
    logic s, k;
    int d0;
    d0 = done_cnt;
    do_start();
    send_byte({a, 1'b0});
    recv_bit(s, k);
    check1({tag, "_addr_ack"}, k, 1'b1);
    recv_byte(d);
    bit_write(1'b1);
    do_stop();
    check8({tag, "_done_pulses"}, 8'(done_cnt - d0), 8'd1);
  endtask

  initial begin
    logic [7:0] rd;
    logic       s, k;
    int         d0;

    rst     = 1'b0;
    scl     = 1'b1;
    sda_drv = 1'b0;
`ifdef EEPROM_WP_EN
    wp      = 1'b0;
`endif
    tick(4);
    check1("rst_sda", sda, 1'b1);
    check1("rst_ack", ack, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_busy", busy, 1'b0);
    rst = 1'b1;
    tick(4);

    rd_xfer("rd_blank", 7'h33, rd);
    check8("rd_blank_data", rd, 8'h00);

    wr_xfer("wr12", 7'h12, 8'hA5);
    rd_xfer("rd12", 7'h12, rd);
    check8("rd12_data", rd, 8'hA5);

    // STOP in the middle of a write byte
    wr_xfer("wr05", 7'h05, 8'h5A);
    d0 = done_cnt;
    do_start();
    send_byte({7'h05, 1'b1});
    recv_bit(s, k);
    check1("part_addr_ack", k, 1'b1);
    for (int i = 0; i < 4; i++) bit_write(1'b1);
    do_stop();
    check1("part_busy", busy, 1'b0);
    check1("part_ack", ack, 1'b0);
    check8("part_no_done", 8'(done_cnt - d0), 8'd0);
    rd_xfer("rd05", 7'h05, rd);
    check8("rd05_data", rd, 8'h5A);

    // Repeated START after address byte and a partial data byte
    wr_xfer("wr7f", 7'h7F, 8'hC3);
    d0 = done_cnt;
    do_start();
    send_byte({7'h7F, 1'b1});
    recv_bit(s, k);
    check1("rs_addr_ack", k, 1'b1);
    for (int i = 0; i < 3; i++) bit_write(1'b0);
    rd_xfer("rs_rd7f", 7'h7F, rd);
    check8("rs_rd7f_data", rd, 8'hC3);
    check8("rs_total_done", 8'(done_cnt - d0), 8'd1);

`ifdef EEPROM_WP_EN
    wp = 1'b1;
    do_start();
    send_byte({7'h01, 1'b1});
    recv_bit(s, k);
    check1("wp_addr_ack", k, 1'b1);
    check1("wp_addr_ack_sda", s, 1'b0);
    send_byte(8'h3C);
    recv_bit(s, k);
    check1("wp_data_nack", k, 1'b0);
    check1("wp_data_nack_sda", s, 1'b1);
    do_stop();
    wp = 1'b0;
    rd_xfer("wp_rd01", 7'h01, rd);
    check8("wp_rd01_data", rd, 8'h00);
`endif

    // Reset while bit 3 of 0xA5 (a 0) is being driven
    do_start();
    send_byte({7'h12, 1'b0});
    recv_bit(s, k);
    check1("rr_addr_ack", k, 1'b1);
    for (int i = 0; i < 3; i++) recv_bit(s, k);
    tick(6);
    check1("rr_bit3_driven", sda, 1'b0);
    check1("rr_busy_before", busy, 1'b1);
    rst = 1'b0;
    tick(1);
    check1("rr_sda_released", sda, 1'b1);
    check1("rr_busy_cleared", busy, 1'b0);
    check1("rr_ack_cleared", ack, 1'b0);
    rst = 1'b1;
    tick(4);
    scl = 1'b1;
    tick(10);
    rd_xfer("rr_rd12", 7'h12, rd);
    check8("rr_rd12_data", rd, 8'h00);
    rd_xfer("rr_rd7f", 7'h7F, rd);
    check8("rr_rd7f_data", rd, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_responder.md
# i2c_eeprom_responder

I2C-style responder side of the EEPROM link: behaves as the memory device addressed by the team's EEPROM initiator. Oversamples `scl`/`sda` on the system clock, detects START/STOP, shifts in a 7-bit word address plus R/W bit, then either stores one received data byte or returns one stored byte. It holds a 128×8 register array and reports each acknowledge on a dedicated `ack` line for initiators that use a side-band acknowledge.

## Interface
- `DEPTH`, 128, number of memory bytes; must equal 2^`ADDR_W`
- `ADDR_W`, 7, word-address width carried in the address byte
- `DATA_W`, 8, data byte width; fixed at 8
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset; sampled on rising `clk`
- `scl`  in  1  serial clock from the initiator
- `sda`  inout  1  serial data; responder drives only `1'b0` or `1'bz`
- `ack`  out  1  high while the responder is ACKing an address or write-data byte
- `done`  out  1  one-`clk` pulse when a transfer completes at STOP
- `busy`  out  1  high from START detection until STOP or reset
- `wp`  in  1  write protect; present only with `EEPROM_WP_EN`

## Operation
- Line conditioning:
  - `scl` and `sda` each pass through a 2-flop synchroniser plus edge detect.
  - START = `sda` fall while `scl` high.
  - STOP = `sda` rise while `scl` high.
  - SCL-rise and SCL-fall are single-cycle events.
- Bit order on the wire is LSB first. The address byte is `{addr[6:0], rw}`, so `rw` is the first bit; `rw` = 1 means write.
- Bits are sampled on SCL-rise. The responder changes `sda` only on SCL-fall.
- States and transitions:
  - IDLE: `sda` released. On START → ADDR, bit count = 0, `busy` = 1.
  - ADDR: sample 8 bits. After the 8th bit, latch `addr`/`rw`, load `mem[addr]` into the read shifter, → ADDR_ACK.
  - ADDR_ACK: on the next SCL-fall, drive `sda` = 0 and set `ack` = 1. On the following SCL-fall, release `sda`, clear `ack`, then go to WDATA if `rw` = 1, else RDATA with bit 0 driven.
  - WDATA: sample 8 bits. After the 8th bit, write `mem[addr]` on the next `clk`, → WDATA_ACK.
  - WDATA_ACK: same ACK timing as ADDR_ACK, then → WAIT_STOP.
  - RDATA: on each SCL-fall, drive bit i as follows: 0 → `sda` = 0; 1 → `sda` = Z. After the 8th bit's SCL-fall, release `sda` and → WAIT_STOP. The initiator's ACK/NACK is ignored.
  - WAIT_STOP: idle until STOP or START.
- Global overrides in any non-IDLE state:
  - STOP → IDLE, `busy` = 0, `sda`/`ack` released. `done` pulses only if reached from WAIT_STOP.
  - START (repeated start) → ADDR with count cleared, no pulse. A partial write byte is discarded and memory is untouched.
- Address is used modulo `DEPTH`. There is no auto-increment; exactly one data byte per transfer.

## Timing
- Reset (`rst` low at a `clk` edge):
  - state IDLE, `sda` Z, `ack` 0, `done` 0, `busy` 0.
  - shifters and counters cleared; all memory bytes 0x00.
  - Reset mid-transfer aborts with no write.
- Latency:
  - START/STOP/SCL-edge detection is 3 `clk` after the pin change.
  - `sda` drive/release is 4 `clk` after the `scl` pin falls.
- Bus constraint: `scl` high and low phases must each be ≥ 6 `clk`. Shorter phases are unsupported.
- Memory write lands 1 `clk` after the 8th write bit's SCL-rise event.
- `ack` is asserted the same `clk` that `sda` is driven low for ACK.
- `done` is asserted the `clk` after the STOP event.

## Configuration
- `EEPROM_WP_EN` defined:
  - `wp` port exists.
  - If `wp` = 1 at the 8th write-data bit, memory is unchanged and WDATA_ACK leaves `sda` Z with `ack` = 0 (NACK).
  - Address ACK and reads are unaffected.
- `EEPROM_WP_EN` undefined: no `wp` port; writes are always accepted.

## Structure
- Package `i2c_pkg`: state enum (IDLE, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, WAIT_STOP), `ADDR_W`/`DATA_W` defaults, `RW_WRITE` = 1.
- Sub-module `i2c_line_sync` (2-flop synchroniser + rise/fall detect), instantiated once for `scl` and once for `sda`.

## Test plan
- Write addr 0x12, data 0xA5:
  - `ack` high during both ACK slots.
  - `done` pulses after STOP.
  - `mem[0x12]` = 0xA5.
- Read addr 0x12 after that write: `sda` sampled on SCL-rise gives 1,0,1,0,0,1,0,1 (0xA5 LSB first). Read after reset returns 0x00.
- STOP after 4 write-data bits to addr 0x05: state IDLE, `mem[0x05]` unchanged, no `done`.
- Repeated START after the address byte, then a read of 0x7F: no write occurs and the correct byte is returned.
- `rst` low during RDATA bit 3: next `clk` has `sda` Z, `busy` 0, and memory cleared.
- With `EEPROM_WP_EN` and `wp` = 1, write 0x3C to 0x01: address ACKed, data NACKed (`ack` 0, `sda` Z), `mem[0x01]` = 0x00.
